key_conditioner: RTL
====================

Name: key_conditioner

Overview:
Upstream input stage for the traffic-light controller. Takes raw active-low pushbuttons (KEY[3:0] on the board). Each channel gets synchronisation, debouncing and edge detection. Produces clean held levels plus single-cycle press and release pulses, which the controller uses for reset, skip and emergency commands.

Parameters:
N_KEYS, 4, number of independent button channels.
DEBOUNCE_CYCLES, 1_000_000, stable-input cycles required before a change is accepted (20 ms at 50 MHz); legal range 2..2^24.
REPEAT_DELAY, 25_000_000, held cycles before the first auto-repeat pulse (used only with KEY_COND_REPEAT_EN).
REPEAT_PERIOD, 10_000_000, cycles between later auto-repeat pulses (used only with KEY_COND_REPEAT_EN).

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
reset_n  input  1  reset, asynchronous assert, active-low.
KEY  input  N_KEYS  raw buttons, asynchronous, active-low (0 = pressed).
key_level  output  N_KEYS  debounced state, 1 = pressed.
key_press  output  N_KEYS  one-cycle pulse on each accepted press (and each repeat, if enabled).
key_release  output  N_KEYS  one-cycle pulse on each accepted release.
any_press  output  1  OR of key_press, registered alongside it (same cycle).

Behaviour:
- One clock domain: CLOCK_50. Reset is asynchronous and active-low on reset_n.
- While reset_n=0:
  - synchroniser flops = 1 (released);
  - all FSMs = IDLE; counters = 0;
  - key_level, key_press, key_release, any_press = 0.
- Per channel:
  - 2-flop synchroniser; s = synchronised KEY, inverted so that 1 = pressed.
  - Counter cnt, width $clog2 of the largest enabled count parameter.
- FSM states and transitions:
  - IDLE: if s=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: if s=0, return to IDLE (bounce rejected, no output). Otherwise cnt++. At cnt==DEBOUNCE_CYCLES-1 with s=1: go to HELD, key_level<=1, key_press<=1 for one cycle, cnt=0.
  - HELD: if s=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: if s=1, return to HELD (no pulse, key_level stays 1). Otherwise cnt++. At cnt==DEBOUNCE_CYCLES-1 with s=0: go to IDLE, key_level<=0, key_release<=1 for one cycle.
- Latency: with KEY stable low from the edge-0 sample, key_press and key_level are high after edge DEBOUNCE_CYCLES+3. Release is symmetric.
- All outputs are registered; pulses are exactly one cycle wide.
- Channels are fully independent. Simultaneous presses on several channels pulse in the same cycle; any_press is a single 1.
- A glitch shorter than DEBOUNCE_CYCLES produces no output in either direction.
- Reset mid-debounce or mid-hold:
  - outputs drop immediately;
  - no release pulse is generated;
  - after reset_n rises with KEY still held, a full debounce runs, then a fresh press pulse.
- Counter never wraps: it is cleared on every state change and saturates at its compare value.

Optional Feature:
Macro KEY_COND_REPEAT_EN.
- Defined: in HELD, cnt counts held cycles.
  - At REPEAT_DELAY-1, key_press pulses and cnt=0.
  - Thereafter key_press pulses every REPEAT_PERIOD cycles while held.
  - Entering RELEASE_WAIT suspends repeat.
  - Returning to HELD from a bounce restarts the REPEAT_DELAY phase.
- Undefined: exactly one key_press per accepted press. REPEAT_* parameters are ignored; repeat logic and the wider counter are not synthesised.

Decomposition:
- Package key_cond_pkg holds:
  - state enum kc_state_t {KC_IDLE, KC_PRESS_WAIT, KC_HELD, KC_RELEASE_WAIT};
  - default timing constants for 50 MHz;
  - the counter-width function.
- Sub-module key_debounce_ch implements one channel: synchroniser, FSM, counter, pulses.
- key_conditioner instantiates N_KEYS copies in a generate loop and registers any_press.

Test Plan:
Bench uses DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
1. Clean press: KEY[0] driven 0 just after edge 0 and held -> key_press[0]=1 for exactly one cycle after edge 11; key_level[0]=1 from then on; other channels stay 0.
2. Bounce: KEY[1] low for 5 cycles, high 2, low 5, then high -> no key_press[1], key_level[1] stays 0.
3. Release with bounce: held KEY[0] goes high 3 cycles, low 2, then high and stable -> key_level stays 1 through the bounce; exactly one key_release[0] after 8+3 stable-high cycles.
4. Simultaneous presses: KEY[2] and KEY[3] go low on the same cycle -> key_press[3:2]=2'b11 in the same cycle; any_press=1 for one cycle.
5. Reset mid-hold: KEY[0] held, reset_n pulsed low for 3 cycles at cycle 30 -> all outputs 0 asynchronously; no key_release. After reset_n rises, key_press[0] returns after edge 11 counted from reset deassertion.
6. Repeat (KEY_COND_REPEAT_EN defined): KEY[0] held 60 cycles -> press pulses at cycles 11, 31, 36, 41, 46, ... Without the macro -> only the cycle-11 pulse.

Source files
------------

// File: rtl/key_cond_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
// Shared types and constants for the pushbutton conditioner.
//   kc_state_t     : per-channel debounce FSM state
//   KC_*_DEF       : default timing constants for a 50 MHz CLOCK_50
//   kc_cnt_width() : width needed for a counter that reaches max_count-1
//   kc_max3()      : largest of three counts (sizes the shared counter)
// -----------------------------------------------------------------------------
package key_cond_pkg;

   typedef enum logic [1:0] {
      KC_IDLE,
      KC_PRESS_WAIT,
      KC_HELD,
      KC_RELEASE_WAIT
   } kc_state_t;

   localparam int KC_N_KEYS_DEF        = 4;
   localparam int KC_DEBOUNCE_DEF      = 1_000_000;   // 20 ms
   localparam int KC_REPEAT_DELAY_DEF  = 25_000_000;  // 500 ms
   localparam int KC_REPEAT_PERIOD_DEF = 10_000_000;  // 200 ms

   // The counter only ever holds 0 .. max_count-1, so $clog2(max_count)
   // bits suffice; a one-bit floor keeps tiny counts legal.
   function automatic int kc_cnt_width(input int max_count);
      return (max_count <= 2) ? 1 : $clog2(max_count);
   endfunction

   function automatic int kc_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One pushbutton channel: 2-flop synchroniser, debounce FSM with a saturating
// counter, registered held level and one-cycle press/release pulses.
//
// Build option: define KEY_COND_REPEAT_EN to add auto-repeat press pulses
// while the button stays held (first after REPEAT_DELAY, then every
// REPEAT_PERIOD cycles). Without it the repeat logic and wider counter vanish.
//
// Ports
//   CLOCK_50    in   system clock
//   reset_n     in   asynchronous active-low reset
//   key_raw     in   raw button, active-low, asynchronous
//   key_level   out  debounced state, 1 = pressed
//   key_press   out  one-cycle pulse per accepted press (and repeat)
//   key_release out  one-cycle pulse per accepted release
//   press_nxt   out  combinational next value of key_press, so the parent
//                    can register an aggregate in the same cycle
// -----------------------------------------------------------------------------
module key_debounce_ch
   import key_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEF
`ifdef KEY_COND_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = KC_REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = KC_REPEAT_PERIOD_DEF
`endif
) (
   input  logic CLOCK_50,
   input  logic reset_n,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic press_nxt
);

`ifdef KEY_COND_REPEAT_EN
   localparam int CNT_W = kc_cnt_width(kc_max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`else
   localparam int CNT_W = kc_cnt_width(DEBOUNCE_CYCLES);
`endif
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             key_sync_p0;
   logic             key_sync_p1;
   logic             s;
   kc_state_t        state;
   kc_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             level_nxt;
   logic             release_nxt;
`ifdef KEY_COND_REPEAT_EN
   // 0 = waiting out REPEAT_DELAY, 1 = in the REPEAT_PERIOD cadence
   logic             rpt_fast;
   logic             rpt_fast_nxt;
   logic [CNT_W-1:0] rpt_last;
`endif

   assign s = ~key_sync_p1;

   // ---- next-state / output decode ----
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      level_nxt   = key_level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
`ifdef KEY_COND_REPEAT_EN
      rpt_fast_nxt = rpt_fast;
      rpt_last     = rpt_fast ? RP_LAST : RD_LAST;
`endif
      case (state)
         KC_IDLE: begin
            if (s) begin
               state_nxt = KC_PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         KC_PRESS_WAIT: begin
            if (!s) begin
               state_nxt = KC_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt = KC_HELD;
               cnt_nxt   = '0;
               level_nxt = 1'b1;
               press_nxt = 1'b1;
`ifdef KEY_COND_REPEAT_EN
               rpt_fast_nxt = 1'b0;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         KC_HELD: begin
            if (!s) begin
               state_nxt = KC_RELEASE_WAIT;
               cnt_nxt   = '0;
            end
`ifdef KEY_COND_REPEAT_EN
            else if (cnt == rpt_last) begin
               press_nxt    = 1'b1;
               cnt_nxt      = '0;
               rpt_fast_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
`endif
         end
         KC_RELEASE_WAIT: begin
            if (s) begin
               // bounce: back to held, repeat timing starts over
               state_nxt = KC_HELD;
               cnt_nxt   = '0;
`ifdef KEY_COND_REPEAT_EN
               rpt_fast_nxt = 1'b0;
`endif
            end else if (cnt == DB_LAST) begin
               state_nxt   = KC_IDLE;
               cnt_nxt     = '0;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = KC_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ---- synchroniser stages p0/p1, then FSM and output registers ----
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         key_sync_p0 <= 1'b1;
         key_sync_p1 <= 1'b1;
         state       <= KC_IDLE;
         cnt         <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
`ifdef KEY_COND_REPEAT_EN
         rpt_fast    <= 1'b0;
`endif
      end else begin
         key_sync_p0 <= key_raw;
         key_sync_p1 <= key_sync_p0;
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
`ifdef KEY_COND_REPEAT_EN
         rpt_fast    <= rpt_fast_nxt;
`endif
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Input stage for the traffic-light controller: conditions N_KEYS raw
// active-low pushbuttons into clean held levels and single-cycle press and
// release pulses. Each channel is an independent key_debounce_ch.
//
// Build option: KEY_COND_REPEAT_EN enables auto-repeat press pulses while a
// key is held; REPEAT_DELAY / REPEAT_PERIOD are ignored without it.
//
// Ports
//   CLOCK_50    in   50 MHz system clock
//   reset_n     in   asynchronous active-low reset
//   KEY         in   [N_KEYS] raw buttons, active-low (0 = pressed)
//   key_level   out  [N_KEYS] debounced state, 1 = pressed
//   key_press   out  [N_KEYS] one-cycle pulse per accepted press / repeat
//   key_release out  [N_KEYS] one-cycle pulse per accepted release
//   any_press   out  OR of key_press, registered in the same cycle
// -----------------------------------------------------------------------------
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int N_KEYS          = KC_N_KEYS_DEF,
   parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEF,
   parameter int REPEAT_DELAY    = KC_REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = KC_REPEAT_PERIOD_DEF
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic              any_press
);

   localparam bit PARAMS_OK = (N_KEYS >= 1) &&
                              (DEBOUNCE_CYCLES >= 2) && (DEBOUNCE_CYCLES <= 2**24) &&
                              (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

   if (!PARAMS_OK) begin : g_bad_params
      $error("key_conditioner: parameter out of legal range");
   end

   logic [N_KEYS-1:0] press_nxt;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_COND_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_ch (
         .CLOCK_50    (CLOCK_50),
         .reset_n     (reset_n),
         .key_raw     (KEY[i]),
         .key_level   (key_level[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .press_nxt   (press_nxt[i])
      );
   end

   // ---- aggregate press, registered on the same edge as key_press ----
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         any_press <= 1'b0;
      end else begin
         any_press <= |press_nxt;
      end
   end

endmodule
